// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    D0   = 2'd1,
    D1   = 2'd2,
    D2   = 2'd3
  } state_t;

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Index 0 is the rightmost element; 10..15 show a dash.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH,
    SEG_DASH, SEG_DASH, SEG_DASH,
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder, active-high.
// Codes above 9 decode to a dash.
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/bcd_display_scan.sv
// 3-digit multiplexed 7-segment scanner with frame snapshot,
// anti-ghost gap cycle and leading-zero blanking.
module bcd_display_scan
  import display_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       BlankEn,
  input  logic [3:0] Co1,
  input  logic [3:0] Co10,
  input  logic [3:0] Co100,
  output logic [6:0] Seg,
  output logic [2:0] An,
  output logic       FrameTick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_MASK =
    SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_MASK =
    AN_ACTIVE_LOW ? 3'b111 : 3'b000;

  logic [CW-1:0] cnt;
  logic          tick;
  state_t        state;
  state_t        state_nxt;
  logic          frame_start;

  logic [3:0]    snap_u;
  logic [3:0]    snap_t;
  logic [3:0]    snap_h;
  logic          snap_blank;

  logic [3:0]    digit;
  logic [2:0]    an_raw;
  logic          blank_slot;
  logic          lit;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_raw;
  logic [2:0]    an_sel;

  assign tick = (cnt == LAST);

  // Refresh prescaler: one tick per digit slot.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  // Scan state register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next digit on each tick; entering D0 starts a frame.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          state_nxt   = D0;
          frame_start = 1'b1;
        end
        D0: state_nxt = D1;
        D1: state_nxt = D2;
        D2: begin
          state_nxt   = D0;
          frame_start = 1'b1;
        end
      endcase
    end
  end

  // Frame snapshot so one frame never mixes counter values.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      snap_u     <= '0;
      snap_t     <= '0;
      snap_h     <= '0;
      snap_blank <= 1'b0;
    end else if (frame_start) begin
      snap_u     <= Co1;
      snap_t     <= Co10;
      snap_h     <= Co100;
      snap_blank <= BlankEn;
    end
  end

  // Digit select and blanking; a nonzero higher digit
  // (including invalid codes) keeps lower digits visible.
  always_comb begin
    digit      = snap_u;
    an_raw     = 3'b001;
    blank_slot = 1'b0;
    case (state)
      D1: begin
        digit      = snap_t;
        an_raw     = 3'b010;
        blank_slot = snap_blank
                  && (snap_h == 4'd0)
                  && (snap_t == 4'd0);
      end
      D2: begin
        digit      = snap_h;
        an_raw     = 3'b100;
        blank_slot = snap_blank && (snap_h == 4'd0);
      end
      default: ;
    endcase
  end

  bcd_to_7seg u_dec (
    .bcd (digit),
    .seg (dec_seg)
  );

  // The tick cycle loads "off" so the next cycle is the gap.
  assign lit     = !tick && (state != IDLE);
  assign seg_raw = (lit && !blank_slot) ? dec_seg : SEG_OFF;
  assign an_sel  = lit ? an_raw : 3'b000;

  // Registered pins; polarity applied only here.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Seg       <= SEG_MASK;
      An        <= AN_MASK;
      FrameTick <= 1'b0;
    end else begin
      Seg       <= seg_raw ^ SEG_MASK;
      An        <= an_sel ^ AN_MASK;
      FrameTick <= frame_start;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan, REFRESH_DIV=4,
// active-high segments and anodes.
module tb_bcd_display_scan;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic       BlankEn = 1'b0;
  logic [3:0] Co1 = 4'd0;
  logic [3:0] Co10 = 4'd0;
  logic [3:0] Co100 = 4'd0;
  logic [6:0] Seg;
  logic [2:0] An;
  logic       FrameTick;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0] an;
    logic [6:0] seg;
  } slot_t;

  slot_t sb[$];

  bcd_display_scan #(
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1'b0),
    .AN_ACTIVE_LOW  (1'b0)
  ) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .BlankEn   (BlankEn),
    .Co1       (Co1),
    .Co10      (Co10),
    .Co100     (Co100),
    .Seg       (Seg),
    .An        (An),
    .FrameTick (FrameTick)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic push_slot(input logic [2:0] an,
                           input logic [6:0] seg);
    slot_t s;
    s.an  = an;
    s.seg = seg;
    sb.push_back(s);
  endtask

  task automatic push_frame(input logic [3:0] h,
                            input logic [3:0] t,
                            input logic [3:0] u,
                            input logic b);
    logic bh;
    logic bt;
    bh = b && (h == 4'd0);
    bt = bh && (t == 4'd0);
    push_slot(3'b001, ref_seg(u));
    push_slot(3'b010, bt ? 7'h00 : ref_seg(t));
    push_slot(3'b100, bh ? 7'h00 : ref_seg(h));
  endtask

  task automatic set_inputs(input logic [3:0] h,
                            input logic [3:0] t,
                            input logic [3:0] u,
                            input logic b);
    Co100   = h;
    Co10    = t;
    Co1     = u;
    BlankEn = b;
  endtask

  // Pop one expected slot per lit DUT slot and check it.
  task automatic check_slots(input int n);
    for (int i = 0; i < n; i++) begin
      slot_t e;
      int    w;
      int    lit;
      w = 0;
      while (An !== 3'b000 && w < 20) begin
        @(negedge Clock);
        w++;
      end
      w = 0;
      while (An === 3'b000 && w < 20) begin
        @(negedge Clock);
        w++;
      end
      n_checks++;
      if (w >= 20 || sb.size() == 0) begin
        n_fail++;
        $display("FAIL slot_wait: timeout or empty queue (q=%0d)",
                 sb.size());
        return;
      end
      e = sb.pop_front();
      if (An !== e.an || Seg !== e.seg) begin
        n_fail++;
        $display("FAIL slot_value: An=%b Seg=%h expected An=%b Seg=%h",
                 An, Seg, e.an, e.seg);
      end
      lit = 0;
      while (An === e.an && lit < 10) begin
        lit++;
        @(negedge Clock);
      end
      n_checks++;
      if (lit != 3) begin
        n_fail++;
        $display("FAIL slot_len: lit %0d cycles expected 3", lit);
      end
    end
  endtask

  task automatic wait_frame();
    int w;
    w = 0;
    do begin
      @(negedge Clock);
      w++;
    end while (FrameTick !== 1'b1 && w < 20);
    n_checks++;
    if (FrameTick !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_wait: FrameTick=%b expected 1", FrameTick);
    end
  endtask

  // Checks the dark cycles, gap and first lit units slot
  // after a release of nReset at a falling edge.
  task automatic check_startup(input logic [6:0] units_seg);
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clock);
      n_checks++;
      if (k < 4) begin
        if (An !== 3'b000 || Seg !== 7'h00 || FrameTick !== 1'b0) begin
          n_fail++;
          $display("FAIL startup_dark c%0d: An=%b Seg=%h FT=%b expected 000/00/0",
                   k, An, Seg, FrameTick);
        end
      end else if (k == 4) begin
        if (An !== 3'b000 || Seg !== 7'h00 || FrameTick !== 1'b1) begin
          n_fail++;
          $display("FAIL startup_gap: An=%b Seg=%h FT=%b expected 000/00/1",
                   An, Seg, FrameTick);
        end
      end else begin
        if (An !== 3'b001 || Seg !== units_seg) begin
          n_fail++;
          $display("FAIL startup_lit: An=%b Seg=%h expected 001/%h",
                   An, Seg, units_seg);
        end
      end
    end
  endtask

  task automatic test_reset();
    set_inputs(4'd1, 4'd2, 4'd3, 1'b0);
    nReset = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      n_checks++;
      if (An !== 3'b000 || Seg !== 7'h00 || FrameTick !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: An=%b Seg=%h FT=%b expected 000/00/0",
                 An, Seg, FrameTick);
      end
    end
    nReset = 1'b1;
    check_startup(7'h4F);
  endtask

  task automatic test_frame();
    push_slot(3'b010, 7'h5B);
    push_slot(3'b100, 7'h06);
    push_frame(4'd1, 4'd2, 4'd3, 1'b0);
    check_slots(5);
  endtask

  task automatic test_frame_period();
    int gap;
    wait_frame();
    gap = 0;
    do begin
      @(negedge Clock);
      gap++;
    end while (FrameTick !== 1'b1 && gap < 30);
    n_checks++;
    if (gap != 12) begin
      n_fail++;
      $display("FAIL frame_period: %0d cycles expected 12", gap);
    end
  endtask

  task automatic test_mid_frame();
    int w;
    w = 0;
    while (An !== 3'b010 && w < 20) begin
      @(negedge Clock);
      w++;
    end
    @(negedge Clock);
    set_inputs(4'd4, 4'd5, 4'd6, 1'b0);
    @(negedge Clock);
    n_checks++;
    if (An !== 3'b010 || Seg !== 7'h5B) begin
      n_fail++;
      $display("FAIL mid_frame_hold: An=%b Seg=%h expected 010/5b",
               An, Seg);
    end
    push_slot(3'b100, ref_seg(4'd1));
    push_frame(4'd4, 4'd5, 4'd6, 1'b0);
    check_slots(4);
  endtask

  task automatic test_blank(input logic [3:0] h,
                            input logic [3:0] t,
                            input logic [3:0] u);
    set_inputs(h, t, u, 1'b1);
    wait_frame();
    push_frame(h, t, u, 1'b1);
    check_slots(3);
  endtask

  task automatic test_reset_mid();
    int w;
    w = 0;
    while (An !== 3'b100 && w < 20) begin
      @(negedge Clock);
      w++;
    end
    @(negedge Clock);
    nReset = 1'b0;
    #1;
    n_checks++;
    if (An !== 3'b000 || Seg !== 7'h00 || FrameTick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: An=%b Seg=%h FT=%b expected 000/00/0",
               An, Seg, FrameTick);
    end
    @(negedge Clock);
    nReset = 1'b1;
    check_startup(ref_seg(Co1));
    push_slot(3'b010, ref_seg(4'd0));
    push_slot(3'b100, ref_seg(4'hC));
    check_slots(2);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_frame_period();
    test_mid_frame();
    test_blank(4'd0, 4'd0, 4'd7);
    test_blank(4'd0, 4'd0, 4'd0);
    test_blank(4'hC, 4'd0, 4'd0);
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
